mem_bus_interface: RTL and testbench

- Bridges the multi-cycle control unit and the external 16-bit memory bus (readM, writeM, address, bidirectional data).
- Accepts one access request at a time and holds the bus signals stable for a fixed memory latency.
- Captures read data into the instruction register (fetch) or the memory data register (load), then pulses done.
- Maintains the retired-fetch counter that drives num_inst.

---
 rtl/mem_bus_interface.sv | 151 +++++++++++++++
 tb/tb_mem_bus_interface.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_interface.sv
// -----------------------------------------------------------------------------
// mem_bus_interface
//
// Bridges the multi-cycle control unit to the external memory bus. One request
// is accepted at a time. The bus strobes and address are then held stable for
// LATENCY cycles. Read data is captured into the instruction register (fetch)
// or the memory data register (load), and a one-cycle done pulse follows.
// Completed fetches are counted in num_inst.
//
// Ports:
//   clk        in   system clock, rising edge
//   Reset_N    in   asynchronous reset, active-high (legacy name)
//   req_valid  in   control unit requests an access
//   req_ready  out  interface is idle and can accept a request
//   req_write  in   1 = store, 0 = read
//   req_fetch  in   read is an instruction fetch (ignored for stores)
//   req_addr   in   access address
//   req_wdata  in   store data
//   done       out  one-cycle completion pulse
//   inst_reg   out  last fetched instruction
//   mdr        out  last loaded data word
//   num_inst   out  modulo count of completed fetches
//   readM      out  memory read strobe
//   writeM     out  memory write strobe
//   address    out  memory address (holds last value when idle)
//   data       io   memory data bus, driven only while a store is in progress
// -----------------------------------------------------------------------------
module mem_bus_interface #(
  parameter int WORD_SIZE = 16,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 Reset_N,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic                 req_fetch,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 done,
  output logic [WORD_SIZE-1:0] inst_reg,
  output logic [WORD_SIZE-1:0] mdr,
  output logic [WORD_SIZE-1:0] num_inst,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data
);

  // A zero (or too large) latency cannot be represented by the 4-bit countdown.
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_bus_interface: LATENCY must be in 1..15");
  end

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]           state_q, state_d;
  logic [3:0]           cnt_q,   cnt_d;
  logic [WORD_SIZE-1:0] addr_q,  addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 write_q, write_d;
  logic                 fetch_q, fetch_d;
  logic [WORD_SIZE-1:0] inst_q,  inst_d;
  logic [WORD_SIZE-1:0] mdr_q,   mdr_d;
  logic [WORD_SIZE-1:0] num_inst_q, num_inst_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    fetch_d    = fetch_q;
    inst_d     = inst_q;
    mdr_d      = mdr_q;
    num_inst_d = num_inst_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_ACCESS;
          cnt_d   = CNT_INIT;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
          // A store that also claims to be a fetch is a plain store.
          fetch_d = req_fetch & ~req_write;
        end
      end
      S_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_DONE;
          if (!write_q) begin
            if (fetch_q) begin
              inst_d     = data;
              num_inst_d = num_inst_q + WORD_SIZE'(1);
            end else begin
              mdr_d = data;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Reset is asynchronous so an in-flight access is abandoned immediately,
  // dropping strobes and releasing the bus without waiting for a clock edge.
  always_ff @(posedge clk or posedge Reset_N) begin
    if (Reset_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      fetch_q    <= 1'b0;
      inst_q     <= '0;
      mdr_q      <= '0;
      num_inst_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      fetch_q    <= fetch_d;
      inst_q     <= inst_d;
      mdr_q      <= mdr_d;
      num_inst_q <= num_inst_d;
    end
  end

  // All bus and handshake outputs decode straight from registered state, so
  // they are glitch-free with respect to the request inputs.
  assign req_ready = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign readM     = (state_q == S_ACCESS) && !write_q;
  assign writeM    = (state_q == S_ACCESS) &&  write_q;
  assign address   = addr_q;
  assign inst_reg  = inst_q;
  assign mdr       = mdr_q;
  assign num_inst  = num_inst_q;
  assign data      = writeM ? wdata_q : 'z;

endmodule

// File: tb/tb_mem_bus_interface.sv
// -----------------------------------------------------------------------------
// Directed testbench for mem_bus_interface (WORD_SIZE=16, LATENCY=2).
// The memory model returns mem_rdata while readM is high and otherwise parks
// the bus at 16'hA5A5 unless writeM is high; the park value stands in for
// "released" so a DUT that drives the bus out of turn disturbs it.
// -----------------------------------------------------------------------------
module tb_mem_bus_interface;

  localparam int W   = 16;
  localparam int LAT = 2;
  localparam logic [W-1:0] PARK = 16'hA5A5;

  logic         clk = 1'b0;
  logic         Reset_N;
  logic         req_valid, req_write, req_fetch;
  logic [W-1:0] req_addr, req_wdata;
  logic         req_ready, done, readM, writeM;
  logic [W-1:0] inst_reg, mdr, num_inst, address;
  wire  [W-1:0] data;
  logic [W-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign data = writeM ? 'z : (readM ? mem_rdata : PARK);

  mem_bus_interface #(.WORD_SIZE(W), .LATENCY(LAT)) dut (
    .clk(clk), .Reset_N(Reset_N),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_fetch(req_fetch),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .inst_reg(inst_reg), .mdr(mdr), .num_inst(num_inst),
    .readM(readM), .writeM(writeM), .address(address), .data(data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request from IDLE and watches the following six cycles.
  // Expected: strobe high in samples 0..LAT-1, done only in sample LAT.
  task automatic access(input string tag, input logic wr, input logic fe,
                        input logic [W-1:0] a, input logic [W-1:0] wd,
                        input logic [W-1:0] rd);
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, done_at = -1, bad_addr = 0, bad_data = 0;
    req_valid = 1'b1; req_write = wr; req_fetch = fe;
    req_addr = a; req_wdata = wd; mem_rdata = rd;
    tick();
    req_valid = 1'b0;
    req_addr  = ~a;
    req_wdata = ~wd;
    for (int i = 0; i < 6; i++) begin
      if (readM)  rd_cnt++;
      if (writeM) wr_cnt++;
      if (done) begin done_cnt++; done_at = i; end
      if (address !== a) bad_addr++;
      if (i < LAT && wr && data !== wd) bad_data++;
      if (!(i < LAT && wr) && !(i < LAT && !wr) && data !== PARK) bad_data++;
      if (i < LAT && !wr && data !== rd) bad_data++;
      tick();
    end
    chk({tag, "_readM_cycles"},  rd_cnt,   wr ? 0 : LAT);
    chk({tag, "_writeM_cycles"}, wr_cnt,   wr ? LAT : 0);
    chk({tag, "_done_count"},    done_cnt, 1);
    chk({tag, "_done_at"},       done_at,  LAT);
    chk({tag, "_addr_stable"},   bad_addr, 0);
    chk({tag, "_data_bus"},      bad_data, 0);
    chk({tag, "_ready_after"},   req_ready, 1'b1);
  endtask

  initial begin
    int dn;
    Reset_N = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_fetch = 1'b0;
    req_addr = '0; req_wdata = '0; mem_rdata = '0;
    #3;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_readM", readM, 1'b0);
    chk("rst_writeM", writeM, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_address", address, 16'h0000);
    chk("rst_inst", inst_reg, 16'h0000);
    chk("rst_mdr", mdr, 16'h0000);
    chk("rst_num", num_inst, 16'h0000);
    chk("rst_bus", data, PARK);
    tick(); tick();
    Reset_N = 1'b0;
    tick();

    // Fetch
    access("fetch", 1'b0, 1'b1, 16'h0004, 16'h0000, 16'h6A05);
    chk("fetch_inst", inst_reg, 16'h6A05);
    chk("fetch_num", num_inst, 16'h0001);
    chk("fetch_mdr", mdr, 16'h0000);

    // Load
    access("load", 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1234);
    chk("load_mdr", mdr, 16'h1234);
    chk("load_inst", inst_reg, 16'h6A05);
    chk("load_num", num_inst, 16'h0001);

    // Store
    access("store", 1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000);
    chk("store_mdr", mdr, 16'h1234);
    chk("store_inst", inst_reg, 16'h6A05);
    chk("store_num", num_inst, 16'h0001);

    // Reset mid-access of a fetch
    req_valid = 1'b1; req_write = 1'b0; req_fetch = 1'b1;
    req_addr = 16'h0030; mem_rdata = 16'h7777;
    tick();
    req_valid = 1'b0;
    chk("abort_readM_before", readM, 1'b1);
    #2 Reset_N = 1'b1;
    #1;
    chk("abort_readM", readM, 1'b0);
    chk("abort_ready", req_ready, 1'b1);
    chk("abort_done", done, 1'b0);
    chk("abort_bus", data, PARK);
    chk("abort_address", address, 16'h0000);
    chk("abort_num", num_inst, 16'h0000);
    #1 Reset_N = 1'b0;
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) dn++;
    end
    chk("abort_no_done", dn, 0);
    chk("abort_inst", inst_reg, 16'h0000);
    chk("abort_num_after", num_inst, 16'h0000);

    // Back-to-back fetches with req_valid held and req_addr changing each cycle
    req_valid = 1'b1; req_write = 1'b0; req_fetch = 1'b1;
    req_addr = 16'h0100; mem_rdata = 16'h1111;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) dn++;
      if (i == 0) chk("b2b_addr0", address, 16'h0100);
      if (i == 1) chk("b2b_addr_held", address, 16'h0100);
      if (i == 1) chk("b2b_ready_busy", req_ready, 1'b0);
      if (i == 4) chk("b2b_addr_second", address, 16'h0104);
      if (i == 10) chk("b2b_third_done", done, 1'b1);
      req_addr = 16'h0100 + 16'(i + 1);
    end
    req_valid = 1'b0;
    chk("b2b_done_count", dn, 3);
    chk("b2b_num", num_inst, 16'h0003);
    tick();

    // Counter wrap
    force dut.num_inst_q = 16'hFFFF;
    #1;
    release dut.num_inst_q;
    chk("wrap_preload", num_inst, 16'hFFFF);
    access("wrap_fetch", 1'b0, 1'b1, 16'h0040, 16'h0000, 16'h2222);
    chk("wrap_num", num_inst, 16'h0000);
    chk("wrap_inst", inst_reg, 16'h2222);

    // Store flagged as fetch: plain store
    access("wf", 1'b1, 1'b1, 16'h0050, 16'hCAFE, 16'h3333);
    chk("wf_num", num_inst, 16'h0000);
    chk("wf_inst", inst_reg, 16'h2222);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
